// File: rtl/md5_dispatcher_if.sv
// Host word-stream handshake into md5_dispatcher: one 32-bit message word per accepted beat,
// with the block tag sampled alongside word 0.
interface md5_dispatcher_if #(
  parameter int TAG_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;

  modport master (output in_valid, in_data, in_tag, input in_ready);
  modport slave  (input in_valid, in_data, in_tag, output in_ready);
endinterface

// File: rtl/md5_dispatcher.sv
// md5_dispatcher: loads host blocks into the two md5unit lanes round-robin and reports digest matches.
// Optional per-lane watchdog is built only when MD5_TIMEOUT_EN is defined.
module md5_dispatcher #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TAG_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  md5_dispatcher_if.slave   host,
  input  logic [127:0]      target_i,
  output logic [1:0]        unit_reset_o,
  output logic [1:0]        unit_start_o,
  output logic              unit_write_o,
  output logic [31:0]       unit_writedata_o,
  output logic [4:0]        unit_writeaddr_o,
  input  logic [127:0]      unit_digest0_i,
  input  logic [127:0]      unit_digest1_i,
  input  logic [1:0]        unit_done_i,
  output logic              match_valid_o,
  output logic [TAG_W-1:0]  match_tag_o,
  output logic              match_lane_o,
  output logic [31:0]       blocks_done_o,
  output logic              busy_o,
  output logic [1:0]        timeout_err_o
);
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_START} load_e;
  typedef enum logic [1:0] {S_IDLE, S_LOADING, S_RUNNING, S_COMPLETE} lane_e;

  load_e            load_q;
  lane_e            lane_q [2];
  logic             sel_q, last_q;
  logic [3:0]       idx_q;
  logic             in_ready_q, rst_hold_q;
  logic [1:0]       unit_reset_q, unit_start_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [4:0]       waddr_q;
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       mask_q [2];
  logic [1:0]       eq_q;
  logic             match_valid_q, match_lane_q;
  logic [TAG_W-1:0] match_tag_q;
  logic [31:0]      blocks_q;
  logic [127:0]     digest [2];
  logic             pick_ok_d, pick_d, rep_ok_d, rep_d;

`ifdef MD5_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       terr_q;
  assign timeout_err_o = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_err_o  = 2'b00;
`endif

  assign digest[0] = unit_digest0_i;
  assign digest[1] = unit_digest1_i;

  // Round-robin lane pick prefers the lane after the last one used; lane 0 reports before lane 1.
  always_comb begin
    pick_ok_d = 1'b0;
    pick_d    = ~last_q;
    if (lane_q[~last_q] == S_IDLE) begin
      pick_ok_d = 1'b1;
    end else if (lane_q[last_q] == S_IDLE) begin
      pick_ok_d = 1'b1;
      pick_d    = last_q;
    end
    rep_ok_d = 1'b0;
    rep_d    = 1'b0;
    if (lane_q[0] == S_COMPLETE) begin
      rep_ok_d = 1'b1;
    end else if (lane_q[1] == S_COMPLETE) begin
      rep_ok_d = 1'b1;
      rep_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q        <= L_IDLE;
      sel_q         <= 1'b0;
      last_q        <= 1'b1;
      idx_q         <= '0;
      in_ready_q    <= 1'b0;
      rst_hold_q    <= 1'b1;
      unit_reset_q  <= 2'b11;
      unit_start_q  <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      waddr_q       <= '0;
      eq_q          <= '0;
      match_valid_q <= 1'b0;
      match_lane_q  <= 1'b0;
      match_tag_q   <= '0;
      blocks_q      <= '0;
      for (int l = 0; l < 2; l++) begin
        lane_q[l] <= S_IDLE;
        tag_q[l]  <= '0;
        mask_q[l] <= '0;
`ifdef MD5_TIMEOUT_EN
        cnt_q[l]  <= '0;
`endif
      end
`ifdef MD5_TIMEOUT_EN
      terr_q <= '0;
`endif
    end else begin
      unit_start_q  <= '0;
      wr_q          <= 1'b0;
      match_valid_q <= 1'b0;
      rst_hold_q    <= 1'b0;
      unit_reset_q  <= {2{rst_hold_q}};

      case (load_q)
        L_IDLE: begin
          if (pick_ok_d) begin
            sel_q          <= pick_d;
            last_q         <= pick_d;
            lane_q[pick_d] <= S_LOADING;
            idx_q          <= '0;
            in_ready_q     <= 1'b1;
            load_q         <= L_LOAD;
          end
        end
        L_LOAD: begin
          if (host.in_valid) begin
            wr_q    <= 1'b1;
            wdata_q <= host.in_data;
            waddr_q <= {sel_q, idx_q};
            idx_q   <= idx_q + 4'd1;
            if (idx_q == 4'd0) tag_q[sel_q] <= host.in_tag;
            if (idx_q == 4'd15) begin
              in_ready_q <= 1'b0;
              load_q     <= L_START;
            end
          end
        end
        L_START: begin
          unit_start_q[sel_q] <= 1'b1;
          lane_q[sel_q]       <= S_RUNNING;
          mask_q[sel_q]       <= 2'd2;
`ifdef MD5_TIMEOUT_EN
          cnt_q[sel_q]        <= '0;
`endif
          load_q              <= L_IDLE;
        end
        default: load_q <= L_IDLE;
      endcase

      // The start cycle and the one after it may still show the previous block's done level.
      for (int l = 0; l < 2; l++) begin
        if (lane_q[l] == S_RUNNING) begin
          if (mask_q[l] != 2'd0) begin
            mask_q[l] <= mask_q[l] - 2'd1;
          end else if (unit_done_i[l]) begin
            lane_q[l] <= S_COMPLETE;
            eq_q[l]   <= (digest[l] == target_i);
          end
`ifdef MD5_TIMEOUT_EN
          if (!(mask_q[l] == 2'd0 && unit_done_i[l])) begin
            if (cnt_q[l] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              lane_q[l]       <= S_IDLE;
              terr_q[l]       <= 1'b1;
              unit_reset_q[l] <= 1'b1;
            end else begin
              cnt_q[l] <= cnt_q[l] + 1'b1;
            end
          end
`endif
        end
      end

      if (rep_ok_d) begin
        lane_q[rep_d] <= S_IDLE;
        blocks_q      <= blocks_q + 32'd1;
        if (eq_q[rep_d]) begin
          match_valid_q <= 1'b1;
          match_tag_q   <= tag_q[rep_d];
          match_lane_q  <= rep_d;
        end
      end
    end
  end

  assign host.in_ready    = in_ready_q;
  assign unit_reset_o     = unit_reset_q;
  assign unit_start_o     = unit_start_q;
  assign unit_write_o     = wr_q;
  assign unit_writedata_o = wdata_q;
  assign unit_writeaddr_o = waddr_q;
  assign match_valid_o    = match_valid_q;
  assign match_tag_o      = match_tag_q;
  assign match_lane_o     = match_lane_q;
  assign blocks_done_o    = blocks_q;
  assign busy_o           = (load_q != L_IDLE) || (lane_q[0] != S_IDLE) || (lane_q[1] != S_IDLE);
endmodule

// File: tb/tb_md5_dispatcher.sv
// Directed bench for md5_dispatcher with a small behavioural md5unit lane model.
module tb_md5_dispatcher;
  localparam int TAG_W = 16;
  localparam logic [127:0] TARGET = 128'hbaebddf861d3eb2714ba892c2ad26682;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md5_dispatcher_if #(.TAG_W(TAG_W)) host();

  logic [127:0]     target;
  logic [1:0]       unitReset, unitStart, unitDone, timeoutErr;
  logic             unitWrite, matchValid, matchLane, busy;
  logic [31:0]      unitWriteData, blocksDone;
  logic [4:0]       unitWriteAddr;
  logic [127:0]     dig0, dig1;
  logic [TAG_W-1:0] matchTag;

  md5_dispatcher #(.TIMEOUT_CYCLES(512), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .host(host), .target_i(target),
    .unit_reset_o(unitReset), .unit_start_o(unitStart), .unit_write_o(unitWrite),
    .unit_writedata_o(unitWriteData), .unit_writeaddr_o(unitWriteAddr),
    .unit_digest0_i(dig0), .unit_digest1_i(dig1), .unit_done_i(unitDone),
    .match_valid_o(matchValid), .match_tag_o(matchTag), .match_lane_o(matchLane),
    .blocks_done_o(blocksDone), .busy_o(busy), .timeout_err_o(timeoutErr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Lane model: done rises modelDelay cycles after start (0 = never), or both together in simulMode.
  int         modelDelay [2];
  int         remain [2];
  logic [1:0] pending;
  bit         simulMode = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < 2; l++) begin
      if (unitReset[l]) begin
        unitDone[l] <= 1'b0; remain[l] <= 0; pending[l] <= 1'b0;
      end else if (unitStart[l]) begin
        unitDone[l] <= 1'b0; remain[l] <= modelDelay[l]; pending[l] <= 1'b1;
      end else if (!simulMode && remain[l] == 1) begin
        unitDone[l] <= 1'b1; remain[l] <= 0; pending[l] <= 1'b0;
      end else if (!simulMode && remain[l] > 1) begin
        remain[l] <= remain[l] - 1;
      end
    end
    if (simulMode && pending == 2'b11 && unitStart == 2'b00) begin
      unitDone <= 2'b11;
      pending  <= 2'b00;
    end
  end

  // Event log sampled mid-cycle.
  logic [4:0]       wrAddr [64];
  logic [31:0]      wrData [64];
  int               wrCyc [64];
  int               wrN;
  logic [1:0]       stVal [8];
  int               stCyc [8];
  int               stN;
  logic [TAG_W-1:0] mTag [8];
  logic             mLane [8];
  int               mCyc [8];
  int               mN;
  int               doneCyc [2];
  logic [1:0]       prevDone = 2'b00;
  int               urCyc;

  always @(negedge clk) begin
    if (unitWrite && wrN < 64) begin
      wrAddr[wrN] = unitWriteAddr; wrData[wrN] = unitWriteData; wrCyc[wrN] = cyc; wrN++;
    end
    if (unitStart != 2'b00 && stN < 8) begin
      stVal[stN] = unitStart; stCyc[stN] = cyc; stN++;
    end
    if (matchValid && mN < 8) begin
      mTag[mN] = matchTag; mLane[mN] = matchLane; mCyc[mN] = cyc; mN++;
    end
    for (int l = 0; l < 2; l++)
      if (unitDone[l] && !prevDone[l]) doneCyc[l] = cyc;
    prevDone = unitDone;
    if (reset && unitReset == 2'b01) urCyc = cyc;
  end

  logic [31:0] msg [16];
  int          acc [16];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearLog();
    wrN = 0; stN = 0; mN = 0; urCyc = -1;
    doneCyc[0] = -1; doneCyc[1] = -1;
  endtask

  task automatic applyReset();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tick();
    clearLog();
  endtask

  task automatic loadMatchMsg();
    msg = '{32'h01680208, 32'h13ab80bb, 32'hcb8b2c30, 32'hb9657582,
            32'ha3793c48, 32'h103f26be, 32'h0b78dac4, 32'h5c433348,
            32'h4de99287, 32'heff0be7c, 32'h00808533, 32'h00000000,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h0000002a};
  endtask

  // Streams nWords of msg; gapped drops in_valid every other cycle.
  task automatic applyStimulus(input logic [TAG_W-1:0] tag, input bit gapped, input int nWords);
    int i; int guard; bit gap;
    i = 0; guard = 0; gap = 1'b0;
    while (i < nWords && guard < 400) begin
      tick();
      if (gapped && gap) begin
        host.in_valid = 1'b0;
      end else begin
        host.in_valid = 1'b1; host.in_data = msg[i]; host.in_tag = tag;
      end
      if (host.in_valid && host.in_ready) begin
        acc[i] = cyc; i++;
      end
      gap = !gap; guard++;
    end
    checks++;
    if (i != nWords) begin
      errors++; $display("[TB] FAIL load_words got %0d want %0d", i, nWords);
    end
    tick();
    host.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int n);
    int g;
    g = 0;
    while (blocksDone < n && g < 800) begin tick(); g++; end
    checks++;
    if (blocksDone !== n) begin
      errors++; $display("[TB] FAIL blocks_done got %0d want %0d", blocksDone, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (unitReset !== 2'b11) begin errors++; $display("[TB] FAIL rst_unit_reset got %b want 11", unitReset); end
    checks++; if (unitStart !== 2'b00) begin errors++; $display("[TB] FAIL rst_unit_start got %b want 00", unitStart); end
    checks++; if (unitWrite !== 1'b0 || unitWriteAddr !== 5'd0 || unitWriteData !== 32'd0) begin
      errors++; $display("[TB] FAIL rst_write got %b/%h/%h want 0/00/0", unitWrite, unitWriteAddr, unitWriteData); end
    checks++; if (matchValid !== 1'b0 || matchTag !== '0 || matchLane !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_match got %b/%h/%b want 0/0/0", matchValid, matchTag, matchLane); end
    checks++; if (blocksDone !== 32'd0) begin errors++; $display("[TB] FAIL rst_blocks got %0d want 0", blocksDone); end
    checks++; if (busy !== 1'b0 || host.in_ready !== 1'b0 || timeoutErr !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_status got %b/%b/%b want 0/0/00", busy, host.in_ready, timeoutErr); end
    reset = 1'b1;
    tick();
    checks++; if (unitReset !== 2'b11) begin errors++; $display("[TB] FAIL rst_hold got %b want 11", unitReset); end
    tick();
    checks++; if (unitReset !== 2'b00) begin errors++; $display("[TB] FAIL rst_release got %b want 00", unitReset); end
    clearLog();
  endtask

  task automatic test_single_match();
    loadMatchMsg();
    dig0 = TARGET; dig1 = ~TARGET;
    modelDelay[0] = 5; modelDelay[1] = 5;
    clearLog();
    applyStimulus(16'h0001, 1'b0, 16);
    checkOutput(1);
    checks++; if (acc[15] - acc[0] !== 15) begin errors++; $display("[TB] FAIL sm_accept_span got %0d want 15", acc[15] - acc[0]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wrAddr[i] !== 5'(i) || wrData[i] !== msg[i] || wrCyc[i] !== acc[i] + 1) begin
        errors++; $display("[TB] FAIL sm_write%0d got %h/%h@%0d want %h/%h@%0d", i, wrAddr[i], wrData[i], wrCyc[i], 5'(i), msg[i], acc[i] + 1);
      end
    end
    checks++; if (stN !== 1 || stVal[0] !== 2'b01 || stCyc[0] - acc[0] !== 17) begin
      errors++; $display("[TB] FAIL sm_start got n%0d %b@+%0d want n1 01@+17", stN, stVal[0], stCyc[0] - acc[0]); end
    checks++; if (mN !== 1 || mTag[0] !== 16'h0001 || mLane[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL sm_match got n%0d tag %h lane %b want n1 tag 0001 lane 0", mN, mTag[0], mLane[0]); end
    checks++; if (mCyc[0] !== doneCyc[0] + 2) begin
      errors++; $display("[TB] FAIL sm_latency got %0d want %0d", mCyc[0], doneCyc[0] + 2); end
  endtask

  task automatic test_mismatch_rr();
    int a15;
    applyReset();
    loadMatchMsg();
    dig0 = TARGET; dig1 = TARGET ^ 128'h1;
    modelDelay[0] = 30; modelDelay[1] = 30;
    applyStimulus(16'h0011, 1'b0, 16);
    a15 = acc[15];
    applyStimulus(16'h0002, 1'b0, 16);
    checks++; if (acc[0] - a15 !== 3) begin errors++; $display("[TB] FAIL rr_gap got %0d want 3", acc[0] - a15); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (host.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_ready_low got %b want 0", host.in_ready); end
    end
    checkOutput(2);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wrAddr[16 + i] !== 5'(16 + i)) begin
        errors++; $display("[TB] FAIL rr_addr%0d got %h want %h", i, wrAddr[16 + i], 5'(16 + i));
      end
    end
    checks++; if (mN !== 1 || mTag[0] !== 16'h0011 || mLane[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL rr_match got n%0d tag %h lane %b want n1 tag 0011 lane 0", mN, mTag[0], mLane[0]); end
  endtask

  task automatic test_gapped();
    applyReset();
    dig0 = TARGET;
    modelDelay[0] = 5; modelDelay[1] = 5;
    applyStimulus(16'h0003, 1'b1, 16);
    checkOutput(1);
    checks++; if (wrN !== 16) begin errors++; $display("[TB] FAIL gap_writes got %0d want 16", wrN); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wrAddr[i] !== 5'(i) || wrCyc[i] !== acc[i] + 1) begin
        errors++; $display("[TB] FAIL gap_write%0d got %h@%0d want %h@%0d", i, wrAddr[i], wrCyc[i], 5'(i), acc[i] + 1);
      end
    end
    checks++; if (stCyc[0] !== wrCyc[15] + 1) begin errors++; $display("[TB] FAIL gap_start got %0d want %0d", stCyc[0], wrCyc[15] + 1); end
    checks++; if (mN !== 1 || mTag[0] !== 16'h0003) begin errors++; $display("[TB] FAIL gap_match got n%0d tag %h want n1 tag 0003", mN, mTag[0]); end
  endtask

  task automatic test_simultaneous_done();
    applyReset();
    dig0 = TARGET; dig1 = TARGET;
    simulMode = 1'b1;
    applyStimulus(16'h000a, 1'b0, 16);
    applyStimulus(16'h000b, 1'b0, 16);
    checkOutput(2);
    simulMode = 1'b0;
    checks++; if (doneCyc[0] !== doneCyc[1]) begin errors++; $display("[TB] FAIL sim_done got %0d/%0d want equal", doneCyc[0], doneCyc[1]); end
    checks++; if (mN !== 2) begin errors++; $display("[TB] FAIL sim_count got %0d want 2", mN); end
    checks++; if (mLane[0] !== 1'b0 || mTag[0] !== 16'h000a || mCyc[0] !== doneCyc[0] + 2) begin
      errors++; $display("[TB] FAIL sim_lane0 got %b %h @%0d want 0 000a @%0d", mLane[0], mTag[0], mCyc[0], doneCyc[0] + 2); end
    checks++; if (mLane[1] !== 1'b1 || mTag[1] !== 16'h000b || mCyc[1] !== doneCyc[0] + 3) begin
      errors++; $display("[TB] FAIL sim_lane1 got %b %h @%0d want 1 000b @%0d", mLane[1], mTag[1], mCyc[1], doneCyc[0] + 3); end
  endtask

  task automatic test_reset_midload();
    dig0 = TARGET; dig1 = TARGET;
    modelDelay[0] = 5; modelDelay[1] = 5;
    applyStimulus(16'h0004, 1'b0, 7);
    reset = 1'b0;
    tick();
    checks++; if (blocksDone !== 32'd0 || busy !== 1'b0 || host.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got %0d/%b/%b want 0/0/0", blocksDone, busy, host.in_ready); end
    tick();
    reset = 1'b1;
    tick(); tick();
    clearLog();
    applyStimulus(16'h0005, 1'b0, 16);
    checkOutput(1);
    checks++; if (wrN !== 16 || wrAddr[0] !== 5'd0 || wrAddr[15] !== 5'd15) begin
      errors++; $display("[TB] FAIL mid_addrs got n%0d %h..%h want n16 00..0f", wrN, wrAddr[0], wrAddr[15]); end
    checks++; if (mN !== 1 || mTag[0] !== 16'h0005) begin errors++; $display("[TB] FAIL mid_match got n%0d tag %h want n1 tag 0005", mN, mTag[0]); end
  endtask

`ifdef MD5_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    applyReset();
    dig0 = TARGET; dig1 = TARGET;
    modelDelay[0] = 0; modelDelay[1] = 5;
    applyStimulus(16'h0006, 1'b0, 16);
    g = 0;
    while (urCyc < 0 && g < 700) begin tick(); g++; end
    checks++; if (urCyc - stCyc[0] !== 512) begin errors++; $display("[TB] FAIL to_pulse got %0d want 512", urCyc - stCyc[0]); end
    checks++; if (timeoutErr !== 2'b01 || blocksDone !== 32'd0 || mN !== 0) begin
      errors++; $display("[TB] FAIL to_flag got %b/%0d/%0d want 01/0/0", timeoutErr, blocksDone, mN); end
    modelDelay[0] = 5;
    applyStimulus(16'h0007, 1'b0, 16);
    applyStimulus(16'h0008, 1'b0, 16);
    checkOutput(2);
    checks++; if (wrAddr[32] !== 5'd0 || timeoutErr !== 2'b01 || mN !== 2) begin
      errors++; $display("[TB] FAIL to_reuse got %h/%b/%0d want 00/01/2", wrAddr[32], timeoutErr, mN); end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    host.in_valid = 1'b0; host.in_data = '0; host.in_tag = '0;
    target = TARGET; dig0 = '0; dig1 = '0;
    modelDelay[0] = 5; modelDelay[1] = 5;
    clearLog();
    test_reset();
    test_single_match();
    test_mismatch_rr();
    test_gapped();
    test_simultaneous_done();
    test_reset_midload();
`ifdef MD5_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
